// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Board-input front end for the sequence/digit device. It brings the raw slide
// switches and one raw push button into the clock domain through two-flop
// synchronisers. It then debounces both paths with a candidate/counter scheme,
// so downstream logic sees exactly one clean transition per physical action.
//
// Ports:
//   clock        system clock (CLOCK50), all logic on its rising edge
//   reset        synchronous, active-low reset (KEY[0])
//   data_in      raw asynchronous switches SW[WIDTH-1:0]
//   key_in       raw asynchronous push button, active-low (pressed = 0)
//   data_out     debounced switch word
//   data_changed one-cycle pulse when data_out takes a new value
//   key_level    debounced key state, active-high (1 = held)
//   key_press    one-cycle pulse on the debounced press edge
//   key_release  one-cycle pulse on the debounced release edge
//
// Parameters:
//   WIDTH            number of switch bits conditioned as one group
//   DEBOUNCE_CYCLES  cycles an input must stay constant to be accepted (>= 2)
// -----------------------------------------------------------------------------
module input_conditioner #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             key_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_changed,
  output logic             key_level,
  output logic             key_press,
  output logic             key_release
);

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Switch path state
  logic [WIDTH-1:0] data_s1_q, data_s1_d;
  logic [WIDTH-1:0] data_s2_q, data_s2_d;
  logic [WIDTH-1:0] data_cand_q, data_cand_d;
  logic [CNT_W-1:0] data_cnt_q, data_cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_changed_q, data_changed_d;

  // Key path state (synchroniser and candidate kept in raw polarity, 1 = released)
  logic             key_s1_q, key_s1_d;
  logic             key_s2_q, key_s2_d;
  logic             key_cand_q, key_cand_d;
  logic [CNT_W-1:0] key_cnt_q, key_cnt_d;
  logic             key_level_q, key_level_d;
  logic             key_press_q, key_press_d;
  logic             key_release_q, key_release_d;

  // Switch path next-state logic. The whole word is one candidate, so a change
  // on any bit restarts the count. Bits that settle on different cycles
  // therefore commit together. The counter holds at its maximum instead of
  // wrapping. A commit happens only when the accepted word differs from the
  // current output, which suppresses pulses for bounce-and-return.
  always_comb begin
    data_s1_d      = data_in;
    data_s2_d      = data_s1_q;
    data_cand_d    = data_cand_q;
    data_cnt_d     = data_cnt_q;
    data_out_d     = data_out_q;
    data_changed_d = 1'b0;
    if (data_s2_q != data_cand_q) begin
      data_cand_d = data_s2_q;
      data_cnt_d  = '0;
    end else if (data_cnt_q == CNT_MAX) begin
      if (data_out_q != data_cand_q) begin
        data_out_d     = data_cand_q;
        data_changed_d = 1'b1;
      end
    end else begin
      data_cnt_d = data_cnt_q + CNT_W'(1);
    end
  end

  // Key path next-state logic. This mirrors the switch path on a single bit.
  // The accepted level is the inverse of the raw candidate because the button
  // is active-low. Press and release strobes come from the direction of each
  // accepted change.
  always_comb begin
    key_s1_d      = key_in;
    key_s2_d      = key_s1_q;
    key_cand_d    = key_cand_q;
    key_cnt_d     = key_cnt_q;
    key_level_d   = key_level_q;
    key_press_d   = 1'b0;
    key_release_d = 1'b0;
    if (key_s2_q != key_cand_q) begin
      key_cand_d = key_s2_q;
      key_cnt_d  = '0;
    end else if (key_cnt_q == CNT_MAX) begin
      if (key_level_q != ~key_cand_q) begin
        key_level_d   = ~key_cand_q;
        key_press_d   = ~key_cand_q;
        key_release_d = key_cand_q;
      end
    end else begin
      key_cnt_d = key_cnt_q + CNT_W'(1);
    end
  end

  // All state registers. Reset clears everything so that no strobe fires.
  // The key synchroniser and candidate reset to the released level, so a
  // button held through reset is accepted as a fresh press afterwards.
  always_ff @(posedge clock) begin
    if (!reset) begin
      data_s1_q      <= '0;
      data_s2_q      <= '0;
      data_cand_q    <= '0;
      data_cnt_q     <= '0;
      data_out_q     <= '0;
      data_changed_q <= 1'b0;
      key_s1_q       <= 1'b1;
      key_s2_q       <= 1'b1;
      key_cand_q     <= 1'b1;
      key_cnt_q      <= '0;
      key_level_q    <= 1'b0;
      key_press_q    <= 1'b0;
      key_release_q  <= 1'b0;
    end else begin
      data_s1_q      <= data_s1_d;
      data_s2_q      <= data_s2_d;
      data_cand_q    <= data_cand_d;
      data_cnt_q     <= data_cnt_d;
      data_out_q     <= data_out_d;
      data_changed_q <= data_changed_d;
      key_s1_q       <= key_s1_d;
      key_s2_q       <= key_s2_d;
      key_cand_q     <= key_cand_d;
      key_cnt_q      <= key_cnt_d;
      key_level_q    <= key_level_d;
      key_press_q    <= key_press_d;
      key_release_q  <= key_release_d;
    end
  end

  assign data_out     = data_out_q;
  assign data_changed = data_changed_q;
  assign key_level    = key_level_q;
  assign key_press    = key_press_q;
  assign key_release  = key_release_q;

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
//
// Directed bench for input_conditioner with DEBOUNCE_CYCLES = 4. Each clock
// step drives the inputs, advances a reference model and queues the outputs
// expected after that edge. The outputs are then popped and compared. The
// model uses the latency rule directly: a value is accepted once the
// synchronised input has held it for DEBOUNCE_CYCLES+1 consecutive edges.
// Per-scenario pulse counts are also compared against fixed expectations.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

  localparam int WIDTH    = 4;
  localparam int DEBOUNCE = 4;

  typedef struct packed {
    logic [WIDTH-1:0] data_out;
    logic             data_changed;
    logic             key_level;
    logic             key_press;
    logic             key_release;
  } outs_t;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             key_in;
  logic [WIDTH-1:0] data_out;
  logic             data_changed;
  logic             key_level;
  logic             key_press;
  logic             key_release;

  int checks_total  = 0;
  int checks_passed = 0;
  int cycle         = 0;
  int dc_seen       = 0;
  int kp_seen       = 0;
  int kr_seen       = 0;

  // Reference model state
  logic [WIDTH-1:0] m_ds1, m_ds2, m_dout;
  logic             m_ks1, m_ks2, m_klevel;
  logic [WIDTH-1:0] d_hist[$];
  logic             k_hist[$];
  outs_t            exp_q[$];

  input_conditioner #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DEBOUNCE)
  ) dut (
    .clock(clock),
    .reset(reset),
    .data_in(data_in),
    .key_in(key_in),
    .data_out(data_out),
    .data_changed(data_changed),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release)
  );

  // 50 MHz-style free-running clock
  always #10 clock = ~clock;

  // Advances the model by one rising edge, using the inputs as sampled at
  // that edge. It pushes the outputs expected after the edge onto the
  // scoreboard. The history windows hold the synchronised values seen at each
  // edge. Reset seeds them with the cleared value.
  task automatic modelEdge();
    outs_t e;
    bit    same;
    e = '0;
    if (!reset) begin
      m_ds1    = '0;
      m_ds2    = '0;
      m_ks1    = 1'b1;
      m_ks2    = 1'b1;
      m_dout   = '0;
      m_klevel = 1'b0;
      d_hist.delete();
      d_hist.push_back('0);
      k_hist.delete();
      k_hist.push_back(1'b0);
    end else begin
      d_hist.push_back(m_ds2);
      if (d_hist.size() > DEBOUNCE + 1) void'(d_hist.pop_front());
      same = (d_hist.size() == DEBOUNCE + 1);
      foreach (d_hist[i]) if (d_hist[i] != d_hist[0]) same = 1'b0;
      if (same && d_hist[0] != m_dout) begin
        m_dout         = d_hist[0];
        e.data_changed = 1'b1;
      end
      k_hist.push_back(~m_ks2);
      if (k_hist.size() > DEBOUNCE + 1) void'(k_hist.pop_front());
      same = (k_hist.size() == DEBOUNCE + 1);
      foreach (k_hist[i]) if (k_hist[i] != k_hist[0]) same = 1'b0;
      if (same && k_hist[0] != m_klevel) begin
        m_klevel      = k_hist[0];
        e.key_press   = m_klevel;
        e.key_release = ~m_klevel;
      end
      m_ds2 = m_ds1;
      m_ds1 = data_in;
      m_ks2 = m_ks1;
      m_ks1 = key_in;
    end
    e.data_out  = m_dout;
    e.key_level = m_klevel;
    exp_q.push_back(e);
  endtask

  // Pops the expected outputs for the edge just taken and compares them with
  // the DUT. It also tallies strobes for the per-scenario pulse counts.
  task automatic checkOutput();
    outs_t exp_o, got;
    got   = {data_out, data_changed, key_level, key_press, key_release};
    exp_o = exp_q.pop_front();
    checks_total++;
    assert (got === exp_o) checks_passed++;
    else $error("[TB] FAIL outputs@cycle%0d: got dout=%h dc=%b kl=%b kp=%b kr=%b, expected dout=%h dc=%b kl=%b kp=%b kr=%b",
                cycle, got.data_out, got.data_changed, got.key_level, got.key_press, got.key_release,
                exp_o.data_out, exp_o.data_changed, exp_o.key_level, exp_o.key_press, exp_o.key_release);
    dc_seen += int'(data_changed);
    kp_seen += int'(key_press);
    kr_seen += int'(key_release);
  endtask

  // Holds the given inputs for n clock cycles and checks after every edge.
  task automatic applyStimulus(input logic rst, input logic [WIDTH-1:0] d,
                               input logic k, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      reset   = rst;
      data_in = d;
      key_in  = k;
      @(posedge clock);
      cycle++;
      modelEdge();
      #1;
      checkOutput();
    end
  endtask

  task automatic checkCount(input string tag, input int actual, input int expected);
    checks_total++;
    assert (actual == expected) checks_passed++;
    else $error("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic clearCounts();
    dc_seen = 0;
    kp_seen = 0;
    kr_seen = 0;
  endtask

  initial begin
    reset   = 1'b0;
    data_in = 4'hA;
    key_in  = 1'b0;

    $display("[TB] reset with switches at A and key held");
    clearCounts();
    applyStimulus(1'b0, 4'hA, 1'b0, 3);
    applyStimulus(1'b1, 4'hA, 1'b0, 10);
    checkCount("post_reset_dc", dc_seen, 1);
    checkCount("post_reset_press", kp_seen, 1);
    checkCount("post_reset_dout", int'(data_out), 'hA);

    $display("[TB] clean change to 0 then to 5 with key released");
    applyStimulus(1'b1, 4'h0, 1'b1, 10);
    clearCounts();
    applyStimulus(1'b1, 4'h5, 1'b1, 14);
    checkCount("step5_dc", dc_seen, 1);
    checkCount("step5_dout", int'(data_out), 'h5);

    $display("[TB] bit0 toggling every 2 cycles then settling at 1");
    applyStimulus(1'b1, 4'h0, 1'b1, 10);
    clearCounts();
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, (i % 2 == 0) ? 4'h1 : 4'h0, 1'b1, 2);
    checkCount("toggle_dc", dc_seen, 0);
    clearCounts();
    applyStimulus(1'b1, 4'h1, 1'b1, 10);
    checkCount("settle_dc", dc_seen, 1);

    $display("[TB] short glitch 3 -> 7 -> 3");
    applyStimulus(1'b1, 4'h3, 1'b1, 10);
    clearCounts();
    applyStimulus(1'b1, 4'h7, 1'b1, 3);
    applyStimulus(1'b1, 4'h3, 1'b1, 10);
    checkCount("glitch_dc", dc_seen, 0);
    checkCount("glitch_dout", int'(data_out), 'h3);

    $display("[TB] bouncy key press and release");
    clearCounts();
    applyStimulus(1'b1, 4'h3, 1'b0, 2);
    applyStimulus(1'b1, 4'h3, 1'b1, 2);
    applyStimulus(1'b1, 4'h3, 1'b0, 20);
    applyStimulus(1'b1, 4'h3, 1'b1, 2);
    applyStimulus(1'b1, 4'h3, 1'b0, 2);
    applyStimulus(1'b1, 4'h3, 1'b1, 12);
    checkCount("key_press_count", kp_seen, 1);
    checkCount("key_release_count", kr_seen, 1);
    checkCount("key_dc", dc_seen, 0);

    $display("[TB] reset in the middle of a debounce count");
    applyStimulus(1'b1, 4'h0, 1'b1, 10);
    clearCounts();
    applyStimulus(1'b1, 4'hF, 1'b1, 2);
    applyStimulus(1'b0, 4'hF, 1'b1, 2);
    checkCount("midreset_before_dc", dc_seen, 0);
    applyStimulus(1'b1, 4'hF, 1'b1, 10);
    checkCount("midreset_after_dc", dc_seen, 1);
    checkCount("midreset_dout", int'(data_out), 'hF);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Board-input front end that sits directly upstream of the sequence/digit device.
- Takes the raw slide switches SW[3:0] and one raw push button, and synchronises them into the 50 MHz domain.
- Debounces them and presents a stable 4-bit data word plus one-cycle event strobes.
- Removes metastability and contact bounce so the downstream device sees exactly one clean transition per physical switch or key action.

Parameters:
- WIDTH, 4: number of switch bits conditioned as one group.
- DEBOUNCE_CYCLES, 1000000: cycles an input must stay constant before it is accepted (20 ms at 50 MHz). Legal values are 2 or more. Counter width is $clog2(DEBOUNCE_CYCLES).

Ports:
- clock  input  1  system clock (CLOCK50), all logic on its rising edge.
- reset  input  1  synchronous, active-low reset (KEY[0]).
- data_in  input  WIDTH  raw asynchronous switches SW[WIDTH-1:0].
- key_in  input  1  raw asynchronous push button, active-low (pressed = 0).
- data_out  output  WIDTH  debounced switch word.
- data_changed  output  1  one-cycle pulse when data_out takes a new value.
- key_level  output  1  debounced key state, active-high (1 = held).
- key_press  output  1  one-cycle pulse on the debounced press edge.
- key_release  output  1  one-cycle pulse on the debounced release edge.

Behaviour:
- Reset: one clock; reset is synchronous and active-low. While reset==0 at a rising edge, the following are cleared:
  - data_out=0, data_changed=0, key_level=0, key_press=0, key_release=0.
  - Data synchroniser flops and data candidate = 0; key synchroniser flops and key candidate = 1 (released); both counters = 0.
- Synchroniser: a two-flop chain per bit for data_in and for key_in. No logic between the two flops.
- Data debounce, evaluated each cycle from the 2nd sync stage (s2):
  - If s2 != cand: cand<=s2, cnt<=0.
  - Else if cnt == DEBOUNCE_CYCLES-1: hold cnt. If data_out != cand, then data_out<=cand and data_changed<=1 for that cycle only.
  - Else cnt<=cnt+1.
- Latency: a raw change that is stable before edge E appears on data_out at edge E+DEBOUNCE_CYCLES+2. The same holds for the key path.
- Bounce: any s2 toggle before the counter saturates restarts the count. A glitch shorter than DEBOUNCE_CYCLES never reaches data_out.
- Group semantics: a change on any bit restarts the whole-word count. Bits changing on different cycles commit together as one word with one data_changed pulse.
- Same-value return: if the input bounces away and comes back to the committed value, there is no data_changed pulse.
- Key debounce: an identical candidate/counter structure on the inverted synchronised key.
  - key_level updates when the count saturates.
  - key_press pulses one cycle when key_level goes 0->1; key_release pulses when it goes 1->0.
  - data_changed and key_press may assert in the same cycle; the paths are independent.
- Saturation: counters never wrap. Saturated counters stay at DEBOUNCE_CYCLES-1 until the candidate changes.
- Post-reset: switches already non-zero at reset release produce a commit plus a data_changed pulse DEBOUNCE_CYCLES+2 cycles after release.
- Reset mid-count: all state is cleared, no strobe is emitted, and debounce restarts from zero after release.
- Strobes are registered outputs, never combinational from the inputs.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset held 3 cycles with data_in=4'hA, key_in=0 -> all outputs 0 during reset. After release: data_out=4'hA with data_changed=1 for exactly one cycle at edge 6; key_level=1 and key_press=1 at the same edge.
- data_in 0->4'h5 stable -> data_out=5 exactly 6 edges after the change, one data_changed pulse, none afterwards while stable.
- data_in toggles bit0 every 2 cycles for 20 cycles, then settles at 4'h1 -> data_out stays 0 throughout toggling; commit to 1 with one pulse 6 edges after settling.
- Glitch: data_in 4'h3 -> 4'h7 for 3 cycles -> back to 4'h3 -> no data_changed, data_out remains 3.
- Key press, hold 20 cycles, release, with 2-cycle bounces at each edge -> exactly one key_press and one key_release pulse. key_level high for about 20 cycles; no extra pulses.
- Assert reset 2 cycles after data_in changes 0->4'hF, then release -> no strobe during or before release. data_out=F, with one pulse, 6 edges after release.
